// File: rtl/cmp_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cmp_rr_scheduler
// Purpose  : Round-robin arbiter sharing one unsigned magnitude comparator
//            among R valid/ready requesters; tagged gt/ls/eq response channel.
// Revision : 1.0
// ============================================================================
module cmp_rr_scheduler #(
  parameter int N   = 8,
  parameter int R   = 4,
  parameter int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   i_req_valid,
  output logic [R-1:0]   o_req_ready,
  input  logic [R*N-1:0] i_req_a,
  input  logic [R*N-1:0] i_req_b,
  output logic           o_rsp_valid,
  input  logic           i_rsp_ready,
  output logic [IDW-1:0] o_rsp_id,
  output logic           o_rsp_gt,
  output logic           o_rsp_ls,
  output logic           o_rsp_eq,
  output logic           o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_id;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic           r_rsp_gt;
  logic           r_rsp_ls;
  logic           r_rsp_eq;
  logic           r_busy;

  logic           w_found;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_grant;
  logic [IDW-1:0] w_ptr_next;

  // First valid requester at or after the round-robin pointer, wrapping mod R.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < R; k++) begin
      w_idx = IDW'((int'(r_rr_ptr) + k) % R);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_ptr_next = (w_grant == IDW'(R - 1)) ? '0 : w_grant + IDW'(1);

  // Ready is gated by rst_n so it also drops immediately on reset assertion.
  assign o_req_ready = (rst_n && (r_state == S_IDLE) && w_found) ? (R'(1) << w_grant) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_gt    <= 1'b0;
      r_rsp_ls    <= 1'b0;
      r_rsp_eq    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a      <= i_req_a[w_grant*N +: N];
            r_b      <= i_req_b[w_grant*N +: N];
            r_id     <= w_grant;
            r_rr_ptr <= w_ptr_next;
            r_busy   <= 1'b1;
            r_state  <= S_CMP;
          end
        end
        S_CMP: begin
          r_rsp_gt    <= (r_a > r_b);
          r_rsp_ls    <= (r_a < r_b);
          r_rsp_eq    <= (r_a == r_b);
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_gt    = r_rsp_gt;
  assign o_rsp_ls    = r_rsp_ls;
  assign o_rsp_eq    = r_rsp_eq;
  assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cmp_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_rr_scheduler
// Purpose  : Directed + randomized checks of cmp_rr_scheduler against a
//            transaction-level reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_cmp_rr_scheduler;
  localparam int N   = 8;
  localparam int R   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic           rsp_gt, rsp_ls, rsp_eq, busy;

  always #5 clk = ~clk;

  cmp_rr_scheduler #(.N(N), .R(R), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_id(rsp_id), .o_rsp_gt(rsp_gt), .o_rsp_ls(rsp_ls), .o_rsp_eq(rsp_eq),
    .o_busy(busy)
  );

  typedef struct { int id; logic gt; logic ls; logic eq; int cyc; } rsp_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Requester-side intent
  logic [R-1:0] tb_valid;
  logic [N-1:0] tb_a [R];
  logic [N-1:0] tb_b [R];
  logic         tb_rsp_ready;

  // Reference model: one job in flight at most, response one cycle after accept
  int  m_rr;
  bit  m_busy, m_rvalid;
  int  m_rid;
  bit  m_gt, m_ls, m_eq;
  int  job_id;
  int unsigned job_a, job_b;
  rsp_t rsp_log[$];
  int   grant_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    int g;
    logic [R-1:0] exp_ready;
    @(negedge clk);
    for (int i = 0; i < R; i++) begin
      req_a[i*N +: N] = tb_a[i];
      req_b[i*N +: N] = tb_b[i];
    end
    req_valid = tb_valid;
    rsp_ready = tb_rsp_ready;
    #1;
    cyc++;
    g = -1;
    if (!m_busy)
      for (int k = 0; k < R; k++)
        if (g < 0 && tb_valid[(m_rr + k) % R]) g = (m_rr + k) % R;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rvalid));
    if (m_rvalid) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_rid));
      chk("rsp_gt", 32'(rsp_gt), 32'(m_gt));
      chk("rsp_ls", 32'(rsp_ls), 32'(m_ls));
      chk("rsp_eq", 32'(rsp_eq), 32'(m_eq));
    end
    if (m_rvalid && tb_rsp_ready) begin
      rsp_log.push_back('{int'(rsp_id), rsp_gt, rsp_ls, rsp_eq, cyc});
      m_rvalid = 1'b0;
      m_busy   = 1'b0;
    end else if (m_busy && !m_rvalid) begin
      m_rvalid = 1'b1;
      m_rid    = job_id;
      m_gt     = job_a > job_b;
      m_ls     = job_a < job_b;
      m_eq     = job_a == job_b;
    end else if (g >= 0) begin
      m_busy      = 1'b1;
      job_id      = g;
      job_a       = tb_a[g];
      job_b       = tb_b[g];
      m_rr        = (g + 1) % R;
      tb_valid[g] = 1'b0;
      grant_log.push_back(g);
    end
  endtask

  // Asynchronous reset asserted mid-cycle with vpat on req_valid.
  task automatic do_reset(input logic [R-1:0] vpat);
    @(posedge clk);
    #2;
    req_valid = vpat;
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_flags", {29'd0, rsp_gt, rsp_ls, rsp_eq}, 32'd0);
    repeat (2) @(negedge clk);
    req_valid = '0;
    tb_valid  = '0;
    rst_n     = 1'b1;
    m_rr = 0; m_busy = 1'b0; m_rvalid = 1'b0;
    rsp_log.delete();
    grant_log.delete();
  endtask

  initial begin : main
    int t0;
    logic [3*8-1:0] exp_f;
    logic [N-1:0] ba [4];
    logic [N-1:0] bb [4];
    logic [2:0]   bexp [4];
    rst_n = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    tb_valid = '0; tb_rsp_ready = 1'b1;
    for (int i = 0; i < R; i++) begin tb_a[i] = '0; tb_b[i] = '0; end
    m_rr = 0; m_busy = 1'b0; m_rvalid = 1'b0; m_rid = 0; job_id = 0; job_a = 0; job_b = 0;

    // Single request, latency
    do_reset(4'b1111);
    tb_a[0] = 8'hA1; tb_b[0] = 8'hA1; tb_valid = 4'b0001; tb_rsp_ready = 1'b1;
    t0 = cyc + 1;
    repeat (6) step();
    chk("single_n", 32'(rsp_log.size()), 32'd1);
    if (rsp_log.size() > 0) begin
      chk("single_id", 32'(rsp_log[0].id), 32'd0);
      chk("single_flags", {29'd0, rsp_log[0].gt, rsp_log[0].ls, rsp_log[0].eq}, 32'b001);
      chk("single_lat", 32'(rsp_log[0].cyc - t0), 32'd2);
    end

    // All four valid: order 0..3, one response every 3 cycles
    do_reset(4'b0000);
    tb_a[0] = 8'h0C; tb_b[0] = 8'h0A; tb_a[1] = 8'h03; tb_b[1] = 8'h04;
    tb_a[2] = 8'h00; tb_b[2] = 8'h00; tb_a[3] = 8'hFF; tb_b[3] = 8'h7F;
    tb_valid = 4'b1111; tb_rsp_ready = 1'b1;
    repeat (14) step();
    exp_f = {3'b100, 3'b010, 3'b001, 3'b100};
    chk("all4_n", 32'(rsp_log.size()), 32'd4);
    for (int k = 0; k < rsp_log.size() && k < 4; k++) begin
      chk("all4_id", 32'(rsp_log[k].id), 32'(k));
      chk("all4_flags", {29'd0, rsp_log[k].gt, rsp_log[k].ls, rsp_log[k].eq},
          {29'd0, exp_f[(3-k)*3 +: 3]});
      if (k > 0) chk("all4_spacing", 32'(rsp_log[k].cyc - rsp_log[k-1].cyc), 32'd3);
    end

    // Round-robin: after id1, 0101 grants id2 before id0
    do_reset(4'b0000);
    tb_valid = 4'b0010;
    repeat (4) step();
    tb_valid = 4'b0101;
    repeat (8) step();
    chk("rr_n", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() >= 3) begin
      chk("rr_g0", 32'(grant_log[0]), 32'd1);
      chk("rr_g1", 32'(grant_log[1]), 32'd2);
      chk("rr_g2", 32'(grant_log[2]), 32'd0);
    end

    // Backpressure: hold rsp_ready low in RESP with all requesters pending
    do_reset(4'b0000);
    for (int i = 0; i < R; i++) begin tb_a[i] = 8'(i * 37); tb_b[i] = 8'(100 - i * 20); end
    tb_valid = 4'b1111; tb_rsp_ready = 1'b0;
    repeat (8) step();
    chk("bp_grants_held", 32'(grant_log.size()), 32'd1);
    tb_rsp_ready = 1'b1;
    repeat (12) step();
    chk("bp_grants_all", 32'(grant_log.size()), 32'd4);

    // Unsigned boundaries
    do_reset(4'b0000);
    ba[0] = 8'h01; bb[0] = 8'h02; bexp[0] = 3'b010;
    ba[1] = 8'h80; bb[1] = 8'h7F; bexp[1] = 3'b100;
    ba[2] = 8'hFF; bb[2] = 8'hFF; bexp[2] = 3'b001;
    ba[3] = 8'h00; bb[3] = 8'hFF; bexp[3] = 3'b010;
    for (int k = 0; k < 4; k++) begin
      tb_a[k] = ba[k]; tb_b[k] = bb[k]; tb_valid[k] = 1'b1;
      repeat (4) step();
    end
    chk("bnd_n", 32'(rsp_log.size()), 32'd4);
    for (int k = 0; k < rsp_log.size() && k < 4; k++)
      chk("bnd_flags", {29'd0, rsp_log[k].gt, rsp_log[k].ls, rsp_log[k].eq}, {29'd0, bexp[k]});

    // Reset during CMP with id2 in flight
    do_reset(4'b0000);
    tb_valid = 4'b0100;
    step();
    do_reset(4'b1001);
    tb_valid = 4'b1001;
    repeat (8) step();
    chk("mid_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) begin
      chk("mid_first", 32'(grant_log[0]), 32'd0);
      chk("mid_second", 32'(grant_log[1]), 32'd3);
    end
    chk("mid_rsps", 32'(rsp_log.size()), 32'd2);
    for (int k = 0; k < rsp_log.size(); k++)
      chk("mid_no_id2", 32'(rsp_log[k].id != 2), 32'd1);

    // Randomized traffic with drops and backpressure
    do_reset(4'b0000);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < R; i++) begin
        if (!tb_valid[i] && $urandom_range(0, 2) == 0) begin
          tb_valid[i] = 1'b1;
          tb_a[i] = 8'($urandom);
          case ($urandom_range(0, 3))
            0: tb_b[i] = tb_a[i];
            1: tb_b[i] = tb_a[i] + 8'd1;
            2: tb_b[i] = tb_a[i] - 8'd1;
            default: tb_b[i] = 8'($urandom);
          endcase
        end else if (tb_valid[i] && $urandom_range(0, 31) == 0) begin
          tb_valid[i] = 1'b0;
        end
      end
      tb_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
